// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the fetch PC sequencer.
// Latency: n/a (types, constants and one pure helper function only).
// Backpressure: n/a.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } pc_state_e;

  localparam logic [31:0] PC_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] PC_TRAP_VEC  = 32'h0000_0100;
  localparam logic [31:0] PC_STEP      = 32'd4;

  // Fetch addresses are word aligned; the low two bits of any target are dropped.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/status bundle between the pipeline control logic and the PC sequencer.
// Latency: n/a (wires only).
// Backpressure: stall_i holds the PC; there is no valid/ready on this bundle.
// Ports: master drives stall/branch/trap/halt/resume requests and observes PC,
//        next PC, fetch_valid, flush, state and redirect count; slave is the sequencer.
interface pc_sequencer_if;
  import pc_seq_pkg::*;

  logic        stall_i;
  logic        br_taken_i;
  logic [31:0] br_target_i;
  logic        trap_i;
  logic        halt_i;
  logic        resume_i;

  logic [31:0] pc_o;
  logic [31:0] pc_next_o;
  logic        fetch_valid_o;
  logic        flush_o;
  pc_state_e   state_o;
  logic [15:0] redirect_cnt_o;

  modport master (
    output stall_i, br_taken_i, br_target_i, trap_i, halt_i, resume_i,
    input  pc_o, pc_next_o, fetch_valid_o, flush_o, state_o, redirect_cnt_o
  );

  modport slave (
    input  stall_i, br_taken_i, br_target_i, trap_i, halt_i, resume_i,
    output pc_o, pc_next_o, fetch_valid_o, flush_o, state_o, redirect_cnt_o
  );

endinterface

// File: rtl/pc_pend_buf.sv
// One-entry buffer holding a redirect target that could not be applied yet.
// Latency: written value visible on dout/valid one cycle after wr.
// Backpressure: none; a new wr overwrites the held target, clr wins over wr.
// Ports: clk, rst (async active-high), wr/din load, clr empties, valid/dout show content.
module pc_pend_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr,
  input  logic        clr,
  input  logic [31:0] din,
  output logic        valid,
  output logic [31:0] dout
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      dout  <= 32'h0;
    end else if (clr) begin
      valid <= 1'b0;
    end else if (wr) begin
      valid <= 1'b1;
      dout  <= din;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: BOOT/RUN/HALT FSM with trap, branch and deferred-branch redirects.
// Latency: redirects and sequential steps show on pc_o one cycle after the request.
// Backpressure: stall_i holds the PC; branches seen while stalled or halted are deferred.
// Ports: clk, rst (async active-high), bus (slave modport of pc_sequencer_if).
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = PC_RESET_VEC,
  parameter logic [31:0] TRAP_VEC  = PC_TRAP_VEC
) (
  input  logic          clk,
  input  logic          rst,
  pc_sequencer_if.slave bus
);

  pc_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [15:0] cnt_q, cnt_d;
  logic        flush_q;
  logic        fetch_valid_q;

  logic        redirect;
  logic        pend_wr;
  logic        pend_clr;
  logic        pend_valid;
  logic [31:0] pend_dout;
  logic [31:0] br_tgt;

  assign br_tgt = align_pc(bus.br_target_i);

  pc_pend_buf u_pend (
    .clk   (clk),
    .rst   (rst),
    .wr    (pend_wr),
    .clr   (pend_clr),
    .din   (br_tgt),
    .valid (pend_valid),
    .dout  (pend_dout)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    redirect = 1'b0;
    pend_wr  = 1'b0;
    pend_clr = 1'b0;

    if (bus.trap_i) begin
      // Trap overrides everything, in every state, stalled or not.
      state_d  = ST_RUN;
      pc_d     = TRAP_VEC;
      redirect = 1'b1;
      pend_clr = 1'b1;
    end else begin
      case (state_q)
        ST_BOOT: begin
          // Reset vector is fetched for exactly one cycle; an early branch is kept.
          state_d = ST_RUN;
          pend_wr = bus.br_taken_i;
        end
        ST_HALT: begin
          if (bus.resume_i) state_d = ST_RUN;
          pend_wr = bus.br_taken_i;
        end
        ST_RUN: begin
          if (bus.halt_i) begin
            state_d = ST_HALT;
          end else if (bus.br_taken_i && !bus.stall_i) begin
            // A fresh branch supersedes any deferred one.
            pc_d     = br_tgt;
            redirect = 1'b1;
            pend_clr = 1'b1;
          end else if (pend_valid && !bus.stall_i) begin
            pc_d     = pend_dout;
            redirect = 1'b1;
            pend_clr = 1'b1;
          end else if (bus.stall_i) begin
            pend_wr = bus.br_taken_i;
          end else begin
            pc_d = pc_q + PC_STEP;
          end
        end
        default: begin
          state_d = ST_BOOT;
          pc_d    = RESET_VEC;
        end
      endcase
    end

    cnt_d = (redirect && (cnt_q != 16'hFFFF)) ? cnt_q + 16'd1 : cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_VEC;
      cnt_q         <= 16'h0;
      flush_q       <= 1'b0;
      fetch_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      cnt_q         <= cnt_d;
      flush_q       <= redirect;
      fetch_valid_q <= (state_d == ST_RUN);
    end
  end

  assign bus.pc_o           = pc_q;
  assign bus.pc_next_o      = pc_d;
  assign bus.fetch_valid_o  = fetch_valid_q;
  assign bus.flush_o        = flush_q;
  assign bus.state_o        = state_q;
  assign bus.redirect_cnt_o = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pc_sequencer_if bus();

  pc_sequencer #(.RESET_VEC(RV), .TRAP_VEC(TV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: architectural PC, mode (0 boot, 1 run, 2 halt), deferred target queue.
  logic [31:0] m_pc;
  logic [1:0]  m_state;
  logic [31:0] m_pend[$];
  logic        m_flush;
  logic [15:0] m_cnt;

  task automatic model_reset();
    m_pc = RV; m_state = 2'd0; m_pend.delete(); m_flush = 1'b0; m_cnt = 16'h0;
  endtask

  task automatic model_step(output logic [31:0] nxt);
    logic        redir;
    logic [31:0] tgt;
    logic [31:0] aligned;
    logic [1:0]  ns;
    redir   = 1'b0;
    tgt     = m_pc;
    ns      = m_state;
    aligned = bus.br_target_i & 32'hFFFF_FFFC;
    if (bus.trap_i) begin
      redir = 1'b1; tgt = TV; m_pend.delete(); ns = 2'd1;
    end else if (m_state == 2'd0) begin
      ns = 2'd1;
      if (bus.br_taken_i) begin m_pend.delete(); m_pend.push_back(aligned); end
    end else if (m_state == 2'd2) begin
      if (bus.resume_i) ns = 2'd1;
      if (bus.br_taken_i) begin m_pend.delete(); m_pend.push_back(aligned); end
    end else if (bus.halt_i) begin
      ns = 2'd2;
    end else if (!bus.stall_i && bus.br_taken_i) begin
      redir = 1'b1; tgt = aligned; m_pend.delete();
    end else if (!bus.stall_i && m_pend.size() != 0) begin
      redir = 1'b1; tgt = m_pend.pop_front();
    end else if (bus.stall_i) begin
      if (bus.br_taken_i) begin m_pend.delete(); m_pend.push_back(aligned); end
    end else begin
      tgt = m_pc + 32'd4;
    end
    nxt     = tgt;
    m_pc    = tgt;
    m_state = ns;
    m_flush = redir;
    if (redir && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
  endtask

  task automatic clear_pulses();
    bus.br_taken_i = 1'b0; bus.trap_i = 1'b0; bus.halt_i = 1'b0; bus.resume_i = 1'b0;
  endtask

  task automatic tick();
    logic [31:0] nx;
    model_step(nx);
    @(posedge clk); #1;
    clear_pulses();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; bus.stall_i = 1'b0; clear_pulses();
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int exp_pc[5] = '{0, 0, 4, 8, 12};
    #3;
    checks++;
    if ({bus.pc_o, bus.state_o, bus.fetch_valid_o, bus.flush_o, bus.redirect_cnt_o} !== {RV, 2'd0, 1'b0, 1'b0, 16'h0}) begin
      failures++; $display("FAIL reset_async got pc=%h st=%0d fv=%b fl=%b cnt=%h", bus.pc_o, bus.state_o, bus.fetch_valid_o, bus.flush_o, bus.redirect_cnt_o);
    end
    @(posedge clk); #1;
    checks++;
    if ({bus.pc_o, bus.state_o, bus.fetch_valid_o, bus.flush_o} !== {RV, 2'd0, 1'b0, 1'b0}) begin
      failures++; $display("FAIL reset_held got pc=%h st=%0d fv=%b fl=%b", bus.pc_o, bus.state_o, bus.fetch_valid_o, bus.flush_o);
    end
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.pc_o !== 32'(exp_pc[i]) || bus.state_o !== ((i == 0) ? 2'd0 : 2'd1) || bus.fetch_valid_o !== (i != 0)) begin
        failures++; $display("FAIL boot_seq[%0d] got pc=%h st=%0d fv=%b exp pc=%h", i, bus.pc_o, bus.state_o, bus.fetch_valid_o, exp_pc[i]);
      end
      tick();
    end
  endtask

  task automatic test_branch();
    do_reset();
    tick(); tick(); tick();
    checks++;
    if (bus.pc_o !== 32'h8) begin failures++; $display("FAIL br_setup got=%h exp=8", bus.pc_o); end
    bus.br_taken_i = 1'b1; bus.br_target_i = 32'h0000_1003;
    tick();
    checks++;
    if (bus.pc_o !== 32'h1000 || bus.flush_o !== 1'b1 || bus.redirect_cnt_o !== 16'd1) begin
      failures++; $display("FAIL br_apply got pc=%h fl=%b cnt=%0d exp pc=1000 fl=1 cnt=1", bus.pc_o, bus.flush_o, bus.redirect_cnt_o);
    end
    tick();
    checks++;
    if (bus.pc_o !== 32'h1004 || bus.flush_o !== 1'b0 || bus.redirect_cnt_o !== 16'd1) begin
      failures++; $display("FAIL br_after got pc=%h fl=%b cnt=%0d exp pc=1004 fl=0 cnt=1", bus.pc_o, bus.flush_o, bus.redirect_cnt_o);
    end
  endtask

  task automatic test_stall_branch();
    bus.stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin bus.br_taken_i = 1'b1; bus.br_target_i = 32'h200; end
      tick();
      checks++;
      if (bus.pc_o !== 32'h1004 || bus.flush_o !== 1'b0) begin
        failures++; $display("FAIL stall_hold[%0d] got pc=%h fl=%b exp pc=1004 fl=0", i, bus.pc_o, bus.flush_o);
      end
    end
    bus.stall_i = 1'b0;
    tick();
    checks++;
    if (bus.pc_o !== 32'h200 || bus.flush_o !== 1'b1 || bus.redirect_cnt_o !== 16'd2) begin
      failures++; $display("FAIL pend_apply got pc=%h fl=%b cnt=%0d exp pc=200 fl=1 cnt=2", bus.pc_o, bus.flush_o, bus.redirect_cnt_o);
    end
    tick();
    checks++;
    if (bus.pc_o !== 32'h204 || bus.flush_o !== 1'b0) begin
      failures++; $display("FAIL pend_after got pc=%h fl=%b exp pc=204 fl=0", bus.pc_o, bus.flush_o);
    end
  endtask

  task automatic test_trap();
    bus.stall_i = 1'b1;
    bus.br_taken_i = 1'b1; bus.br_target_i = 32'h300;
    tick();
    bus.trap_i = 1'b1; bus.br_taken_i = 1'b1; bus.br_target_i = 32'h500;
    tick();
    checks++;
    if (bus.pc_o !== TV || bus.flush_o !== 1'b1 || bus.redirect_cnt_o !== 16'd3 || bus.state_o !== 2'd1) begin
      failures++; $display("FAIL trap_apply got pc=%h fl=%b cnt=%0d st=%0d exp pc=100 fl=1 cnt=3 st=1", bus.pc_o, bus.flush_o, bus.redirect_cnt_o, bus.state_o);
    end
    tick();
    checks++;
    if (bus.pc_o !== TV || bus.flush_o !== 1'b0) begin
      failures++; $display("FAIL trap_stall got pc=%h fl=%b exp pc=100 fl=0", bus.pc_o, bus.flush_o);
    end
    bus.stall_i = 1'b0;
    tick();
    checks++;
    if (bus.pc_o !== 32'h104 || bus.flush_o !== 1'b0 || bus.redirect_cnt_o !== 16'd3) begin
      failures++; $display("FAIL trap_pend_empty got pc=%h fl=%b cnt=%0d exp pc=104 fl=0 cnt=3", bus.pc_o, bus.flush_o, bus.redirect_cnt_o);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc[4] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
    bus.br_taken_i = 1'b1; bus.br_target_i = 32'hFFFF_FFFA;
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.pc_o !== exp_pc[i]) begin
        failures++; $display("FAIL wrap[%0d] got=%h exp=%h", i, bus.pc_o, exp_pc[i]);
      end
      tick();
    end
  endtask

  task automatic test_saturate();
    do_reset();
    tick();
    for (int i = 0; i < 65535; i++) begin
      bus.br_taken_i = 1'b1;
      bus.br_target_i = (i == 65534) ? 32'h0000_2002 : $urandom;
      tick();
    end
    checks++;
    if (bus.redirect_cnt_o !== 16'hFFFF || bus.pc_o !== 32'h2000) begin
      failures++; $display("FAIL sat_reach got cnt=%h pc=%h exp cnt=ffff pc=2000", bus.redirect_cnt_o, bus.pc_o);
    end
    bus.trap_i = 1'b1;
    tick();
    checks++;
    if (bus.redirect_cnt_o !== 16'hFFFF || bus.pc_o !== TV || bus.flush_o !== 1'b1) begin
      failures++; $display("FAIL sat_hold got cnt=%h pc=%h fl=%b exp cnt=ffff pc=100 fl=1", bus.redirect_cnt_o, bus.pc_o, bus.flush_o);
    end
  endtask

  task automatic test_halt();
    do_reset();
    tick(); tick();
    bus.halt_i = 1'b1;
    tick();
    checks++;
    if (bus.state_o !== 2'd2 || bus.fetch_valid_o !== 1'b0 || bus.pc_o !== 32'h4) begin
      failures++; $display("FAIL halt_enter got st=%0d fv=%b pc=%h exp st=2 fv=0 pc=4", bus.state_o, bus.fetch_valid_o, bus.pc_o);
    end
    tick(); tick();
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (bus.state_o !== 2'd0 || bus.pc_o !== RV || bus.fetch_valid_o !== 1'b0) begin
      failures++; $display("FAIL halt_rst got st=%0d pc=%h fv=%b exp st=0 pc=0 fv=0", bus.state_o, bus.pc_o, bus.fetch_valid_o);
    end
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    tick(); tick();
    bus.halt_i = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.pc_o !== 32'h4 || bus.state_o !== 2'd2 || bus.fetch_valid_o !== 1'b0) begin
        failures++; $display("FAIL halt_hold[%0d] got pc=%h st=%0d fv=%b exp pc=4 st=2 fv=0", i, bus.pc_o, bus.state_o, bus.fetch_valid_o);
      end
    end
    bus.resume_i = 1'b1;
    tick();
    checks++;
    if (bus.state_o !== 2'd1 || bus.fetch_valid_o !== 1'b1 || bus.pc_o !== 32'h4) begin
      failures++; $display("FAIL resume got st=%0d fv=%b pc=%h exp st=1 fv=1 pc=4", bus.state_o, bus.fetch_valid_o, bus.pc_o);
    end
    tick();
    checks++;
    if (bus.pc_o !== 32'h8) begin failures++; $display("FAIL resume_step got=%h exp=8", bus.pc_o); end
  endtask

  task automatic test_random();
    logic [31:0] nx;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if ({bus.pc_o, bus.state_o, bus.fetch_valid_o, bus.flush_o, bus.redirect_cnt_o} !== {RV, 2'd0, 1'b0, 1'b0, 16'h0}) begin
          failures++; $display("FAIL rnd_rst[%0d] got pc=%h st=%0d cnt=%h", n, bus.pc_o, bus.state_o, bus.redirect_cnt_o);
        end
        @(posedge clk); #1;
        rst = 1'b0;
      end else begin
        bus.stall_i     = ($urandom_range(0, 3) == 0);
        bus.br_taken_i  = ($urandom_range(0, 3) == 0);
        bus.br_target_i = $urandom;
        bus.trap_i      = ($urandom_range(0, 29) == 0);
        bus.halt_i      = ($urandom_range(0, 39) == 0);
        bus.resume_i    = ($urandom_range(0, 5) == 0);
        #1;
        model_step(nx);
        checks++;
        if (bus.pc_next_o !== nx) begin
          failures++; $display("FAIL rnd_pc_next[%0d] got=%h exp=%h", n, bus.pc_next_o, nx);
        end
        @(posedge clk); #1;
        clear_pulses();
        checks++;
        if (bus.pc_o !== m_pc || bus.state_o !== m_state || bus.flush_o !== m_flush ||
            bus.fetch_valid_o !== (m_state == 2'd1) || bus.redirect_cnt_o !== m_cnt) begin
          failures++;
          $display("FAIL rnd_out[%0d] got pc=%h st=%0d fl=%b fv=%b cnt=%h exp pc=%h st=%0d fl=%b cnt=%h",
                   n, bus.pc_o, bus.state_o, bus.flush_o, bus.fetch_valid_o, bus.redirect_cnt_o, m_pc, m_state, m_flush, m_cnt);
        end
      end
    end
  endtask

  initial begin
    bus.stall_i = 1'b0; bus.br_target_i = 32'h0;
    clear_pulses();
    model_reset();
    test_reset();
    test_branch();
    test_stall_branch();
    test_trap();
    test_wrap();
    test_halt();
    test_random();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameters SHALL be, one per line:
- RESET_VEC, 32'h0000_0000, fetch address after reset.
- TRAP_VEC, 32'h0000_0100, fetch address on trap.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, asynchronous and active-high.
REQ-004 stall_i  in  1  hazard or imem-not-ready; hold the PC.
REQ-005 br_taken_i  in  1  branch or jump redirect request, one-cycle pulse.
REQ-006 br_target_i  in  32  redirect address, sampled when br_taken_i=1.
REQ-007 trap_i  in  1  trap request, one-cycle pulse.
REQ-008 halt_i / resume_i  in  1 each  enter HALT / leave HALT.
REQ-009 pc_o  out  32  registered current fetch PC.
REQ-010 pc_next_o  out  32  combinational value pc_o takes at the next edge.
REQ-011 fetch_valid_o  out  1  registered; 1 only in RUN.
REQ-012 flush_o  out  1  registered; kills the IF/ID contents.
REQ-013 state_o  out  2  encoding BOOT=0, RUN=1, HALT=2.
REQ-014 redirect_cnt_o  out  16  count of applied redirects.

Function
REQ-015 FSM: BOOT SHALL go to RUN unconditionally after 1 cycle, with pc_o held at RESET_VEC.
REQ-016 RUN per-cycle priority SHALL be: trap_i > halt_i > (br_taken_i & ~stall_i) > (pending & ~stall_i) > stall_i > sequential.
REQ-017 Trap: pc_o SHALL become TRAP_VEC at N+1, the pending buffer SHALL clear, the next state SHALL be RUN, and this SHALL apply in any state and even when stall_i=1.
REQ-018 Halt from RUN: next state SHALL be HALT, pc_o SHALL hold, and fetch_valid_o SHALL be 0 from N+1.
REQ-019 HALT: resume_i SHALL return to RUN; otherwise pc_o SHALL hold.
REQ-020 Branch, not stalled: pc_o SHALL become {br_target_i[31:2],2'b00} at N+1 (bits[1:0] forced to 0).
REQ-021 Branch while stalled or in HALT: the aligned target SHALL be written to a 1-entry pending buffer and pc_o SHALL hold; a later branch SHALL overwrite the buffer.
REQ-022 Pending with stall_i=0 in RUN: pc_o SHALL become the pending target and the buffer SHALL clear; a same-cycle new branch SHALL win and also clear the buffer.
REQ-023 Sequential: pc_o SHALL become pc_o+4, mod 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-024 flush_o SHALL be 1 in exactly the cycle pc_o first shows a trap, branch or pending target, and 0 otherwise.
REQ-025 redirect_cnt_o SHALL increment by 1 per applied redirect (trap, branch or pending) and saturate at 16'hFFFF.
REQ-026 pc_next_o SHALL equal the pc_o value registered at the next edge, in every state.

Reset
REQ-027 While rst=1, regardless of clk, outputs SHALL be: pc_o=RESET_VEC, state BOOT, fetch_valid_o=0, flush_o=0, redirect_cnt_o=0, pending buffer cleared.
REQ-028 Reset asserted mid-redirect or mid-halt SHALL discard all pending state; after release the sequence SHALL restart at BOOT.

Structure
REQ-029 Shared package pc_seq_pkg SHALL hold the state enum/encoding, the RESET_VEC and TRAP_VEC defaults, and PC_STEP=4.
REQ-030 The pending-redirect buffer SHALL be a sub-module pc_pend_buf with ports clk, rst, wr, clr, din[31:0], valid, dout[31:0].

Verification
REQ-031 Reset release, no stimulus -> pc_o: 0 (BOOT), 0 (RUN, fetch_valid_o=1), 4, 8, 12.
REQ-032 br_taken_i with target 32'h0000_1003 at PC=8 -> next pc_o=32'h1000, flush_o=1 one cycle, redirect_cnt_o=1.
REQ-033 stall_i=1 for 3 cycles, branch to 32'h200 during the stall -> pc_o holds; in the first cycle after stall drops pc_o=32'h200 with flush_o=1.
REQ-034 trap_i and br_taken_i together, stall_i=1 -> pc_o=32'h100, flush_o=1, pending buffer empty afterwards.
REQ-035 Sequential run from pc_o=32'hFFFF_FFF8 -> pc_o: FFFF_FFFC, 0, 4; redirect_cnt_o preset to FFFF plus one redirect -> stays FFFF.
REQ-036 halt_i, then rst pulse mid-HALT -> BOOT, pc_o=0; halt/resume sequence -> pc_o held throughout HALT, increments resume on return to RUN.
